// File: rtl/lsu_pkg.sv
// Shared types and bench address constants for the load/store sub-word master.
package lsu_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      RESP
   } state_e;

   localparam logic [31:0] SW_ADDR  = 32'h0001_0000;
   localparam logic [31:0] LED_ADDR = 32'h0001_0004;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: extracts and extends load data, and merges store data
// into a previously read word.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdbuf,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_lane,
   input  size_e       i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte  = i_rdbuf[{i_lane, 3'b000} +: 8];
      w_half  = i_lane[1] ? i_rdbuf[31:16] : i_rdbuf[15:0];
      o_load  = i_rdbuf;
      o_merge = i_wdata;
      case (i_size)
         BYTE: begin
            o_load  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            o_merge = i_rdbuf;
            o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
         end
         HALF: begin
            o_load  = {{16{~i_unsigned & w_half[15]}}, w_half};
            o_merge = i_rdbuf;
            o_merge[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
         end
         default: begin
            o_load  = i_rdbuf;
            o_merge = i_wdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu_subword_master.sv
// RV32I load/store initiator onto a word-only memory port; sub-word stores use
// read-modify-write. Optional misalignment trapping: LSU_MISALIGN_CHECK_EN.
module lsu_subword_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_unsigned,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_rsp_valid,
   output logic [31:0]       o_rsp_rdata,
   output logic              o_rsp_misaligned,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_dataW,
   output logic              o_mem_MemRW,
   input  logic [31:0]       i_mem_dataR
);

   state_e            r_state, w_next;
   logic              r_we, r_unsigned, r_mis;
   size_e             r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata, r_rdbuf;

   logic              w_mis;
   size_e             w_size;
   logic [ADDR_W-1:0] w_addr;
   logic [31:0]       w_load, w_merge;

   // Size 11 folds into WORD; it only reaches memory when trapping is disabled.
   always_comb begin
      w_size = (i_req_size == 2'b11) ? WORD : size_e'(i_req_size);
      w_addr = i_req_addr;
`ifdef LSU_MISALIGN_CHECK_EN
      w_mis  = (i_req_size == 2'b11)
             || ((i_req_size == HALF) && i_req_addr[0])
             || ((i_req_size == WORD) && (i_req_addr[1:0] != 2'b00));
`else
      w_mis  = 1'b0;
      if (w_size == HALF)
         w_addr[0] = 1'b0;
      else if (w_size == WORD)
         w_addr[1:0] = 2'b00;
`endif
   end

   lsu_byte_lane u_lane (
      .i_rdbuf    (r_rdbuf),
      .i_wdata    (r_wdata),
      .i_lane     (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_load     (w_load),
      .o_merge    (w_merge)
   );

   always_comb begin
      w_next           = r_state;
      o_req_ready      = 1'b0;
      o_rsp_valid      = 1'b0;
      o_rsp_rdata      = 32'h0;
      o_rsp_misaligned = 1'b0;
      o_mem_addr       = '0;
      o_mem_dataW      = 32'h0;
      o_mem_MemRW      = 1'b0;
      case (r_state)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               if (w_mis)
                  w_next = RESP;
               else if (i_req_we && (w_size == WORD))
                  w_next = WR;
               else
                  w_next = RD;
            end
         end
         RD: begin
            o_mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
            w_next     = r_we ? WR : RESP;
         end
         WR: begin
            o_mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
            o_mem_dataW = (r_size == WORD) ? r_wdata : w_merge;
            o_mem_MemRW = 1'b1;
            w_next      = RESP;
         end
         RESP: begin
            o_rsp_valid      = 1'b1;
            o_rsp_misaligned = r_mis;
            o_rsp_rdata      = (r_we || r_mis) ? 32'h0 : w_load;
            w_next           = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_unsigned <= 1'b0;
         r_mis      <= 1'b0;
         r_size     <= BYTE;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_rdbuf    <= 32'h0;
      end else begin
         r_state <= w_next;
         if ((r_state == IDLE) && i_req_valid) begin
            r_we       <= i_req_we;
            r_unsigned <= i_req_unsigned;
            r_mis      <= w_mis;
            r_size     <= w_size;
            r_addr     <= w_addr;
            r_wdata    <= i_req_wdata;
         end
         if (r_state == RD)
            r_rdbuf <= i_mem_dataR;
      end
   end

endmodule
